// File: rtl/usina_pkg.sv
// Shared definitions for the plant control chain: state codes of the alarm
// manager and the width of its alarm counter. Other plant blocks and the
// bench import the same constants, so the codes have one source of truth.
package usina_pkg;

  // State codes as seen on the 'estado' output
  localparam logic [2:0] ESTADO_NORMAL      = 3'd0;
  localparam logic [2:0] ESTADO_CONFIRMA    = 3'd1;
  localparam logic [2:0] ESTADO_ALARME      = 3'd2;
  localparam logic [2:0] ESTADO_RECONHECIDO = 3'd3;
  localparam logic [2:0] ESTADO_SCRAM       = 3'd4;

  // Width of the saturating alarm entry counter
  localparam int LARGURA_CONTADOR = 8;
  localparam logic [LARGURA_CONTADOR-1:0] CONTADOR_MAX = '1;

  typedef enum logic [2:0] {
    EST_NORMAL      = ESTADO_NORMAL,
    EST_CONFIRMA    = ESTADO_CONFIRMA,
    EST_ALARME      = ESTADO_ALARME,
    EST_RECONHECIDO = ESTADO_RECONHECIDO,
    EST_SCRAM       = ESTADO_SCRAM
  } estado_t;

  // The lamp is lit whenever an alarm is latched, acknowledged or escalated
  function automatic logic acendeLuz(input estado_t e);
    return (e == EST_ALARME) || (e == EST_RECONHECIDO) || (e == EST_SCRAM);
  endfunction

endpackage

// File: rtl/gerenciador_alarme_sirene.sv
// Siren pattern generator: while 'habilita' is high the output is high for
// MEIO_PERIODO cycles, then low for MEIO_PERIODO cycles, repeating. Each new
// enable starts with the high phase. 'fixo' overrides with a steady high.
module gerador_sirene
  import usina_pkg::*;
#(
  parameter int MEIO_PERIODO = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic habilita,
  input  logic fixo,
  output logic sirene
);

  // fase counts edges spent in the current phase; 0 means "not running",
  // which is how a fresh enable is recognised and started high.
  localparam int FASE_W = $clog2(MEIO_PERIODO + 1);
  localparam logic [FASE_W-1:0] FASE_UM  = FASE_W'(1);
  localparam logic [FASE_W-1:0] FASE_FIM = FASE_W'(MEIO_PERIODO);

  logic [FASE_W-1:0] fase;

  // Phase counter and registered siren level, toggling at each phase end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fase   <= '0;
      sirene <= 1'b0;
    end else if (fixo) begin
      fase   <= '0;
      sirene <= 1'b1;
    end else if (!habilita) begin
      fase   <= '0;
      sirene <= 1'b0;
    end else if (fase == '0) begin
      fase   <= FASE_UM;
      sirene <= 1'b1;
    end else if (fase == FASE_FIM) begin
      fase   <= FASE_UM;
      sirene <= ~sirene;
    end else begin
      fase   <= fase + FASE_UM;
    end
  end

endmodule

// File: rtl/gerenciador_alarme.sv
// Alarm manager: filters the raw control-room alarm level, latches it until
// the operator acknowledges, drives siren and lamp, and escalates to a
// latched SCRAM request when the alarm stays unacknowledged too long.
// All outputs are registered and decoded from the next state.
module gerenciador_alarme
  import usina_pkg::*;
#(
  parameter int CONFIRMA     = 4,
  parameter int MEIO_PERIODO = 8,
  parameter int LIMITE_SCRAM = 64,
  parameter int LIBERA       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alarmeSC,
  input  logic                        reconhecer,
  output logic                        sirene,
  output logic                        luzAlarme,
  output logic                        scram,
  output logic [2:0]                  estado,
  output logic [LARGURA_CONTADOR-1:0] contadorAlarmes
);

  // Each counter only has to reach its own limit before the state is left,
  // so sizing by the limit itself is enough and no wrap can occur.
  localparam int CONF_W  = $clog2(CONFIRMA + 1);
  localparam int TIMER_W = $clog2(LIMITE_SCRAM + 1);
  localparam int LIB_W   = $clog2(LIBERA + 1);

  localparam logic [CONF_W-1:0]  CONF_UM      = CONF_W'(1);
  localparam logic [CONF_W-1:0]  CONF_ULTIMO  = CONF_W'(CONFIRMA - 1);
  localparam logic [TIMER_W-1:0] TIMER_UM     = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ULTIMO = TIMER_W'(LIMITE_SCRAM - 1);
  localparam logic [LIB_W-1:0]   LIB_UM       = LIB_W'(1);
  localparam logic [LIB_W-1:0]   LIB_ULTIMO   = LIB_W'(LIBERA - 1);
  localparam logic [LARGURA_CONTADOR-1:0] ALARMES_UM = LARGURA_CONTADOR'(1);

  estado_t                     estadoAtual;
  estado_t                     proximoEstado;
  logic [CONF_W-1:0]           contConfirma;
  logic [CONF_W-1:0]           proxConfirma;
  logic [TIMER_W-1:0]          timerScram;
  logic [TIMER_W-1:0]          proxTimer;
  logic [LIB_W-1:0]            contLibera;
  logic [LIB_W-1:0]            proxLibera;
  logic [LARGURA_CONTADOR-1:0] proxAlarmes;

  assign estado = estadoAtual;

  // Next-state and next-counter decode; every counter holds by default
  always_comb begin
    proximoEstado = estadoAtual;
    proxConfirma  = contConfirma;
    proxTimer     = timerScram;
    proxLibera    = contLibera;
    proxAlarmes   = contadorAlarmes;

    case (estadoAtual)
      EST_NORMAL: begin
        if (alarmeSC) begin
          proximoEstado = EST_CONFIRMA;
          proxConfirma  = CONF_UM;
        end
      end

      EST_CONFIRMA: begin
        if (!alarmeSC) begin
          proximoEstado = EST_NORMAL;
          proxConfirma  = '0;
        end else if (contConfirma == CONF_ULTIMO) begin
          proximoEstado = EST_ALARME;
          proxConfirma  = '0;
          proxTimer     = '0;
          if (contadorAlarmes != CONTADOR_MAX) begin
            proxAlarmes = contadorAlarmes + ALARMES_UM;
          end
        end else begin
          proxConfirma = contConfirma + CONF_UM;
        end
      end

      EST_ALARME: begin
        if (timerScram == TIMER_ULTIMO) begin
          proximoEstado = EST_SCRAM;
        end else if (reconhecer) begin
          proximoEstado = EST_RECONHECIDO;
          proxLibera    = '0;
        end
        proxTimer = timerScram + TIMER_UM;
      end

      EST_RECONHECIDO: begin
        if (alarmeSC) begin
          proxLibera = '0;
        end else if (contLibera == LIB_ULTIMO) begin
          proximoEstado = EST_NORMAL;
          proxLibera    = '0;
        end else begin
          proxLibera = contLibera + LIB_UM;
        end
      end

      EST_SCRAM: begin
        proximoEstado = EST_SCRAM;
      end

      default: begin
        proximoEstado = EST_NORMAL;
      end
    endcase
  end

  // State register, counters and registered lamp/SCRAM outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estadoAtual     <= EST_NORMAL;
      contConfirma    <= '0;
      timerScram      <= '0;
      contLibera      <= '0;
      contadorAlarmes <= '0;
      luzAlarme       <= 1'b0;
      scram           <= 1'b0;
    end else begin
      estadoAtual     <= proximoEstado;
      contConfirma    <= proxConfirma;
      timerScram      <= proxTimer;
      contLibera      <= proxLibera;
      contadorAlarmes <= proxAlarmes;
      luzAlarme       <= acendeLuz(proximoEstado);
      scram           <= (proximoEstado == EST_SCRAM);
    end
  end

  gerador_sirene #(
    .MEIO_PERIODO(MEIO_PERIODO)
  ) uSirene (
    .clk     (clk),
    .rst_n   (rst_n),
    .habilita(proximoEstado == EST_ALARME),
    .fixo    (proximoEstado == EST_SCRAM),
    .sirene  (sirene)
  );

endmodule

// File: tb/tb_gerenciador_alarme.sv
// Bench for gerenciador_alarme: a sample-counting model of the alarm
// behaviour is compared with the DUT every cycle, and directed scenarios
// pin key instants with literal values.
module tb_gerenciador_alarme;
  import usina_pkg::*;

  localparam int CONFIRMA     = 4;
  localparam int MEIO_PERIODO = 8;
  localparam int LIMITE_SCRAM = 64;
  localparam int LIBERA       = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alarmeSC;
  logic       reconhecer;
  logic       sirene;
  logic       luzAlarme;
  logic       scram;
  logic [2:0] estado;
  logic [7:0] contadorAlarmes;

  int checks   = 0;
  int failures = 0;

  gerenciador_alarme #(
    .CONFIRMA    (CONFIRMA),
    .MEIO_PERIODO(MEIO_PERIODO),
    .LIMITE_SCRAM(LIMITE_SCRAM),
    .LIBERA      (LIBERA)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alarmeSC       (alarmeSC),
    .reconhecer     (reconhecer),
    .sirene         (sirene),
    .luzAlarme      (luzAlarme),
    .scram          (scram),
    .estado         (estado),
    .contadorAlarmes(contadorAlarmes)
  );

  always #5 clk = ~clk;

  // Reference model: consecutive-sample counts and age of the alarm
  logic [2:0] mEstado = ESTADO_NORMAL;
  int         mSeq     = 0;
  int         mIdade   = 0;
  int         mBaixos  = 0;
  int         mAlarmes = 0;
  bit         modeloValido = 1'b0;

  // Advance the model on every rising edge from the same sampled inputs
  always @(posedge clk) begin
    if (!rst_n) begin
      mEstado      <= ESTADO_NORMAL;
      mSeq         <= 0;
      mIdade       <= 0;
      mBaixos      <= 0;
      mAlarmes     <= 0;
      modeloValido <= 1'b1;
    end else begin
      case (mEstado)
        ESTADO_NORMAL: if (alarmeSC) begin
          mEstado <= ESTADO_CONFIRMA;
          mSeq    <= 1;
        end
        ESTADO_CONFIRMA: begin
          if (!alarmeSC) mEstado <= ESTADO_NORMAL;
          else if (mSeq + 1 == CONFIRMA) begin
            mEstado  <= ESTADO_ALARME;
            mIdade   <= 0;
            mAlarmes <= (mAlarmes < 255) ? mAlarmes + 1 : 255;
          end else mSeq <= mSeq + 1;
        end
        ESTADO_ALARME: begin
          mIdade <= mIdade + 1;
          if (mIdade + 1 == LIMITE_SCRAM) mEstado <= ESTADO_SCRAM;
          else if (reconhecer) begin
            mEstado <= ESTADO_RECONHECIDO;
            mBaixos <= 0;
          end
        end
        ESTADO_RECONHECIDO: begin
          if (alarmeSC) mBaixos <= 0;
          else if (mBaixos + 1 == LIBERA) mEstado <= ESTADO_NORMAL;
          else mBaixos <= mBaixos + 1;
        end
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string nome, input logic [31:0] atual,
                             input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", nome, atual, esperado, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (modeloValido) begin
      logic expSirene;
      if (mEstado == ESTADO_ALARME) expSirene = ((mIdade / MEIO_PERIODO) % 2) == 0;
      else expSirene = (mEstado == ESTADO_SCRAM);
      checkOutput("model_estado", 32'(estado), 32'(mEstado));
      checkOutput("model_sirene", 32'(sirene), 32'(expSirene));
      checkOutput("model_luz", 32'(luzAlarme),
                  32'(mEstado == ESTADO_ALARME || mEstado == ESTADO_RECONHECIDO ||
                      mEstado == ESTADO_SCRAM));
      checkOutput("model_scram", 32'(scram), 32'(mEstado == ESTADO_SCRAM));
      checkOutput("model_contador", 32'(contadorAlarmes), 32'(mAlarmes));
    end
  end

  // Hold the given inputs for n rising edges, returning on a falling edge
  task automatic applyStimulus(input logic a, input logic r, input logic rn, input int n);
    alarmeSC   = a;
    reconhecer = r;
    rst_n      = rn;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkTudoZero(input string nome);
    checkOutput({nome, "_estado"}, 32'(estado), 32'(ESTADO_NORMAL));
    checkOutput({nome, "_sirene"}, 32'(sirene), 0);
    checkOutput({nome, "_luz"}, 32'(luzAlarme), 0);
    checkOutput({nome, "_scram"}, 32'(scram), 0);
  endtask

  initial begin
    alarmeSC = 1'b0; reconhecer = 1'b0; rst_n = 1'b0;
    applyStimulus(0, 0, 0, 2);
    checkTudoZero("reset");
    checkOutput("reset_contador", 32'(contadorAlarmes), 0);

    // Glitch: three high samples never confirm
    applyStimulus(1, 0, 1, 3);
    checkOutput("glitch_confirma", 32'(estado), 1);
    checkOutput("glitch_sirene", 32'(sirene), 0);
    applyStimulus(0, 0, 1, 1);
    checkTudoZero("glitch_volta");
    checkOutput("glitch_contador", 32'(contadorAlarmes), 0);

    // Sustained alarm: ALARME at edge 4, siren 8 high / 8 low
    applyStimulus(1, 0, 1, 3);
    checkOutput("conf_edge3", 32'(estado), 1);
    applyStimulus(1, 0, 1, 1);
    checkOutput("alarme_edge4", 32'(estado), 2);
    checkOutput("alarme_sirene_E", 32'(sirene), 1);
    checkOutput("alarme_luz_E", 32'(luzAlarme), 1);
    checkOutput("alarme_contador", 32'(contadorAlarmes), 1);
    applyStimulus(1, 0, 1, 7);
    checkOutput("sirene_E7", 32'(sirene), 1);
    applyStimulus(1, 0, 1, 1);
    checkOutput("sirene_E8", 32'(sirene), 0);
    applyStimulus(1, 0, 1, 1);

    // Acknowledge at E+10, then release with an interrupted low run
    applyStimulus(1, 1, 1, 1);
    checkOutput("ack_estado", 32'(estado), 3);
    checkOutput("ack_sirene", 32'(sirene), 0);
    checkOutput("ack_luz", 32'(luzAlarme), 1);
    applyStimulus(0, 0, 1, 2);
    applyStimulus(1, 0, 1, 1);
    applyStimulus(0, 0, 1, 3);
    checkOutput("libera_3baixos", 32'(estado), 3);
    applyStimulus(0, 0, 1, 1);
    checkTudoZero("libera_4baixos");

    // Escalation without acknowledge
    applyStimulus(1, 0, 1, 4);
    checkOutput("esc_contador", 32'(contadorAlarmes), 2);
    applyStimulus(0, 0, 1, 16);
    checkOutput("esc_E16_estado", 32'(estado), 2);
    checkOutput("esc_E16_sirene", 32'(sirene), 1);
    applyStimulus(0, 0, 1, 47);
    checkOutput("esc_E63_estado", 32'(estado), 2);
    applyStimulus(0, 0, 1, 1);
    checkOutput("esc_E64_estado", 32'(estado), 4);
    checkOutput("esc_E64_scram", 32'(scram), 1);
    checkOutput("esc_E64_sirene", 32'(sirene), 1);
    applyStimulus(0, 1, 1, 5);
    checkOutput("scram_ignora_ack", 32'(estado), 4);
    applyStimulus(0, 0, 0, 1);
    checkTudoZero("scram_reset");
    checkOutput("scram_reset_contador", 32'(contadorAlarmes), 0);

    // Acknowledge on the limit edge: SCRAM wins
    applyStimulus(1, 0, 1, 4);
    applyStimulus(1, 0, 1, 63);
    checkOutput("simult_E63", 32'(estado), 2);
    applyStimulus(1, 1, 1, 1);
    checkOutput("simult_E64", 32'(estado), 4);
    applyStimulus(0, 0, 0, 1);

    // Reset mid-ALARME, then a fresh alarm needs full confirmation
    applyStimulus(1, 0, 1, 4);
    applyStimulus(1, 0, 1, 5);
    applyStimulus(1, 0, 0, 1);
    checkTudoZero("rst_alarme");
    checkOutput("rst_alarme_contador", 32'(contadorAlarmes), 0);
    applyStimulus(1, 0, 1, 3);
    checkOutput("rst_alarme_reconf3", 32'(estado), 1);
    applyStimulus(1, 0, 1, 1);
    checkOutput("rst_alarme_reconf4", 32'(estado), 2);

    // Reset at confirm count 2
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 1, 2);
    checkOutput("rst_conf_c2", 32'(estado), 1);
    applyStimulus(1, 0, 0, 1);
    checkTudoZero("rst_conf");
    applyStimulus(1, 0, 1, 3);
    checkOutput("rst_conf_reconf3", 32'(estado), 1);
    applyStimulus(1, 0, 1, 1);
    checkOutput("rst_conf_reconf4", 32'(estado), 2);

    // Alarm counter saturation at 255
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, 0, 1, 4);
      applyStimulus(0, 1, 1, 1);
      applyStimulus(0, 0, 1, 4);
    end
    checkOutput("saturacao_contador", 32'(contadorAlarmes), 255);
    checkOutput("saturacao_estado", 32'(estado), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
